// File: rtl/ffs_pkg.sv
// Shared types and helpers for the find-first-set priority encoder.
package ffs_pkg;

  localparam int FFS_IDX_W = 6;

  typedef struct packed {
    logic                 valid;
    logic [FFS_IDX_W-1:0] idx;
  } ffs_node_t;

  // All-ones "nothing set" sentinel; the low lg_n+1 bits are the result code.
  function automatic logic [FFS_IDX_W:0] ffs_none(input int lg_n);
    return {(FFS_IDX_W+1){1'b1}} >> (FFS_IDX_W - lg_n);
  endfunction

endpackage

// File: rtl/ffs_merge.sv
// One tree node: the lower-numbered child wins whenever it holds a set bit.
import ffs_pkg::*;

module ffs_merge #(
  parameter int LG_W = 2
) (
  input  logic            lo_valid,
  input  logic [LG_W-1:0] lo_idx,
  input  logic            hi_valid,
  input  logic [LG_W-1:0] hi_idx,
  output logic            valid,
  output logic [LG_W-1:0] idx
);

  // Selecting on lo_valid alone keeps X on the hi side from leaking out.
  assign valid = lo_valid | hi_valid;
  assign idx   = lo_valid ? lo_idx : hi_idx;

endmodule

// File: rtl/find_first_set_core.sv
// Find-first-set priority encoder (bit 0 highest priority), LG_N merge levels.
// Define FIND_FIRST_SET_REG_OUT_EN to add a 1-cycle output register.
import ffs_pkg::*;

module find_first_set_core #(
  parameter int LG_N = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [(1<<LG_N)-1:0] in,
  output logic [LG_N:0]        y
);

  localparam int N = 1 << LG_N;
  localparam logic [FFS_IDX_W:0] NONE_ALL = ffs_none(LG_N);
  localparam logic [LG_N:0]      NONE     = NONE_ALL[LG_N:0];

  // Heap layout: node k merges nodes 2k (lo) and 2k+1 (hi); leaf i sits at N+i.
  for (genvar k = 1; k < 2 * N; k++) begin : tree_g
    ffs_node_t n;
    if (k >= N) begin : leaf_g
      assign n = '{valid: in[k-N], idx: FFS_IDX_W'(k - N)};
    end else begin : merge_g
      logic                 m_valid;
      logic [FFS_IDX_W-1:0] m_idx;
      ffs_merge #(
        .LG_W(FFS_IDX_W)
      ) u_merge (
        .lo_valid(tree_g[2*k].n.valid),
        .lo_idx  (tree_g[2*k].n.idx),
        .hi_valid(tree_g[2*k+1].n.valid),
        .hi_idx  (tree_g[2*k+1].n.idx),
        .valid   (m_valid),
        .idx     (m_idx)
      );
      assign n = '{valid: m_valid, idx: m_idx};
    end
  end

  ffs_node_t     root;
  logic [LG_N:0] y_comb;
  logic          unused_idx_hi;

  assign root          = tree_g[1].n;
  assign y_comb        = root.valid ? {1'b0, root.idx[LG_N-1:0]} : NONE;
  assign unused_idx_hi = |root.idx;

`ifdef FIND_FIRST_SET_REG_OUT_EN
  logic [LG_N:0] y_p0;

  // Output register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) y_p0 <= NONE;
    else      y_p0 <= y_comb;
  end

  assign y = y_p0;
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ rst;
  assign y              = y_comb;
`endif

endmodule

// File: tb/tb_find_first_set_core.sv
// Scoreboard bench for find_first_set_core at LG_N=2 and LG_N=5, both builds.
module tb_find_first_set_core;

  logic        clk;
  logic        rst;
  logic [3:0]  in2;
  logic [31:0] in5;
  logic [2:0]  y2;
  logic [5:0]  y5;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  in2;
    logic [31:0] in5;
    logic [2:0]  e2;
    logic [5:0]  e5;
  } item_t;

  item_t sb_q[$];

  find_first_set_core #(.LG_N(2)) u_ffs2 (.clk(clk), .rst(rst), .in(in2), .y(y2));
  find_first_set_core #(.LG_N(5)) u_ffs5 (.clk(clk), .rst(rst), .in(in5), .y(y5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: scan upward from bit 0; no set bit gives the all-ones code.
  function automatic logic [2:0] ref2(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i] === 1'b1) return 3'(i);
    return 3'b111;
  endfunction

  function automatic logic [5:0] ref5(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i] === 1'b1) return 6'(i);
    return 6'h3f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [31:0] b);
    item_t it;
    @(negedge clk);
    #1;
    in2 = a;
    in5 = b;
    it.in2 = a;
    it.in5 = b;
    it.e2  = ref2(a);
    it.e5  = ref5(b);
    sb_q.push_back(it);
  endtask

  // Monitor: result for the vector driven just after the previous negedge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      item_t e;
      e = sb_q.pop_front();
      chk($sformatf("y2 in=%b", e.in2), 32'(y2), 32'(e.e2));
      chk($sformatf("y5 in=%h", e.in5), 32'(y5), 32'(e.e5));
      if (y2[2] == 1'b0) chk($sformatf("winner_set in=%b", e.in2), 32'(e.in2[y2[1:0]]), 32'd1);
    end
  end

  initial begin
    logic [31:0] r;
    rst = 1'b0;
    in2 = 4'b0000;
    in5 = 32'h0;
    #1;
    chk("reset_y2", 32'(y2), 32'h7);
    chk("reset_y5", 32'(y5), 32'h3f);
    #2;
    rst = 1'b1;
    in2 = 4'b0100;
    in5 = 32'h8001_0000;
    @(posedge clk);
    #1;
    chk("first_y2", 32'(y2), 32'h2);
    chk("first_y5", 32'(y5), 32'd16);

`ifdef FIND_FIRST_SET_REG_OUT_EN
    in2 = 4'b0001;
    @(posedge clk);
    #1;
    chk("pre_rst_y2", 32'(y2), 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_y2", 32'(y2), 32'h7);
    chk("async_rst_y5", 32'(y5), 32'h3f);
    #1;
    rst = 1'b1;
`else
    in2 = 4'b0010;
    for (int t = 0; t < 4; t++) begin
      rst = ~rst;
      #3;
      chk($sformatf("comb_ignore_%0d", t), 32'(y2), 32'h1);
    end
`endif

    for (int i = 0; i < 16; i++) drive(4'(i), $urandom);
    for (int i = 0; i < 32; i++) drive(4'($urandom), 32'h1 << i);
    drive(4'b1100, 32'h0);
    for (int i = 0; i < 200; i++) begin
      r = $urandom << $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) r = 32'h0;
      drive(4'($urandom), r);
    end

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      #2;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);

    @(negedge clk);
    in2 = 4'bxx10;
    @(negedge clk);
    #1;
    chk("x_above_winner", 32'(y2), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/find_first_set_core.md
# find_first_set_core

Parameterized find-first-set priority encoder. Given an N-bit request vector (N = 2^LG_N), it returns the index of the lowest-numbered set bit, plus a "none set" flag in the MSB. It is the arbitration core under the fair round-robin scheduler: the scheduler rotates its request vector, feeds it here, and un-rotates the result. An optional output register can be compiled in for timing closure.

## Interface
- LG_N, default 2: log2 of input width. N = 1 << LG_N. Legal range 1..6.
- clk  input  1  clock; used only when the output register is compiled in.
- rst  input  1  reset, asynchronous, active-low (asserted when 0); used only when the output register is compiled in.
- in  input  N  request vector; bit i set means candidate i is present.
- y  output  LG_N+1  result. y[LG_N]=0 means a bit was found, and y[LG_N-1:0] is its index. All-ones means no bit is set.

## Operation
- y = {1'b0, i}, where i is the smallest index with in[i]=1.
- If in == 0, y = all ones ({LG_N+1{1'b1}}). The low bits are then don't-care for consumers but must be all ones.
- Priority is fixed: bit 0 is highest and bit N-1 is lowest. There is no internal state in the combinational build. Fairness is the caller's job.
- Index arithmetic is unsigned LG_N bits, with no wrap-around inside the block.
- Tree implementation:
  - Level 0 forms N leaves of (valid=in[i], idx=i).
  - Each of the LG_N merge levels pairs adjacent nodes (lo, hi). Output is lo if lo.valid, else hi; valid = lo.valid | hi.valid.
  - The root gives (valid, idx). y = valid ? {0, idx} : all ones.
- The result must be independent of X on bits above the first set bit. Simulation with X above the winner must still give a clean index.

## Timing
- Default build is purely combinational.
  - y settles in the same cycle as in.
  - Logic depth is LG_N mux levels.
  - Zero cycles of latency.
  - clk and rst are ignored.
- Registered build (see Configuration):
  - y is registered on the posedge of clk, so latency is 1 cycle.
  - While rst=0, y = all ones immediately, with no clock edge needed.
  - On rst deassertion, the first posedge captures the encoding of in.
  - Reset asserted mid-operation forces all ones asynchronously and discards the pending value.
- There is no handshake. in is sampled every cycle.

## Configuration
- Macro FIND_FIRST_SET_REG_OUT_EN.
- Defined: the output register above is present, giving 1-cycle latency and an async active-low reset value of all ones.
- Undefined: combinational path only. clk and rst are unconnected internally, and the port list is unchanged.

## Structure
- Shared package ffs_pkg holds:
  - function ffs_none(lg_n), which returns the all-ones sentinel;
  - a typedef for the node record (valid bit + index).
- One sub-module, ffs_merge (parameter LG_W, the index width). It merges two child nodes into one and is instantiated N-1 times via a generate tree.
- Top level contains:
  - the leaf formation;
  - the generate tree;
  - the sentinel mux;
  - the optional output register.

## Test plan
- LG_N=2, in=4'b0000 -> y=3'b111; in=4'b0001 -> 3'b000; in=4'b1000 -> 3'b011.
- LG_N=2, in=4'b0110 -> 3'b001; in=4'b1111 -> 3'b000; in=4'b1100 -> 3'b010 (lowest bit wins).
- LG_N=2, exhaustive 16 inputs: check y against a reference loop scanning from bit 0, and check in[y[1:0]]==1 whenever y[2]==0.
- LG_N=5, walking one across bits 0..31 -> y={0,i}. Also in=32'h8000_0000|32'h0001_0000 -> 6'd16.
- Registered build, LG_N=2:
  - rst=0 -> y=3'b111 with no clock.
  - Release rst, drive in=4'b0100, one posedge -> y=3'b010.
  - Assert rst mid-stream -> y=3'b111 immediately.
- Combinational build: toggle clk and rst with in fixed at 4'b0010 -> y stays 3'b001.
